// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data bus, lane steering,
// sign/zero extension, misalignment detection and pipeline stall.
module mem_stage_lsu #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid,
   input  logic             mem_load,
   input  logic             mem_store,
   input  logic [2:0]       mem_funct3,
   input  logic [WIDTH-1:0] mem_addr,
   input  logic [WIDTH-1:0] mem_wdata,
   output logic             stall,
   output logic [WIDTH-1:0] rdata,
   output logic             rdata_valid,
   output logic             misalign,
   output logic             bus_err,
   output logic             bus_req,
   output logic             bus_we,
   output logic [WIDTH-1:0] bus_addr,
   output logic [3:0]       bus_wstrb,
   output logic [WIDTH-1:0] bus_wdata,
   input  logic             bus_ack,
   input  logic [WIDTH-1:0] bus_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [7:0]  cnt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        ld_q;
   logic        access;
   logic        go;
   logic [3:0]  st_strb;
   logic [31:0] st_data;
   logic [7:0]  b_lane;
   logic [15:0] h_lane;
   logic [31:0] ld_ext;

   assign access = mem_valid & (mem_load | mem_store);
   assign go     = (state == IDLE) & access & ~misalign;
   assign stall  = go | (state == BUSY);

   // Halfword needs addr[0]=0, word needs addr[1:0]=0
   always_comb begin
      misalign = 1'b0;
      if (access) begin
         if (mem_funct3[1:0] == 2'b01)
            misalign = mem_addr[0];
         else if (mem_funct3[1:0] == 2'b10)
            misalign = |mem_addr[1:0];
      end
   end

   // Store byte enables and lane-replicated data
   always_comb begin
      st_strb = 4'hF;
      st_data = mem_wdata;
      unique case (mem_funct3[1:0])
         2'b00: begin
            st_strb = 4'b0001 << mem_addr[1:0];
            st_data = {4{mem_wdata[7:0]}};
         end
         2'b01: begin
            st_strb = 4'b0011 << {mem_addr[1], 1'b0};
            st_data = {2{mem_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Select the addressed lane of the read word and extend it
   always_comb begin
      unique case (off_q)
         2'd0:    b_lane = bus_rdata[7:0];
         2'd1:    b_lane = bus_rdata[15:8];
         2'd2:    b_lane = bus_rdata[23:16];
         default: b_lane = bus_rdata[31:24];
      endcase
      h_lane = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      unique case (f3_q)
         3'b000:  ld_ext = {{24{b_lane[7]}}, b_lane};
         3'b001:  ld_ext = {{16{h_lane[15]}}, h_lane};
         3'b100:  ld_ext = {24'd0, b_lane};
         3'b101:  ld_ext = {16'd0, h_lane};
         default: ld_ext = bus_rdata;
      endcase
   end

   // Transfer FSM: issue, wait for ack or timeout, one-cycle release
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
         ld_q        <= 1'b0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         bus_err     <= 1'b0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_wstrb   <= 4'd0;
         bus_wdata   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  bus_req   <= 1'b1;
                  bus_we    <= mem_store;
                  bus_addr  <= {mem_addr[31:2], 2'b00};
                  bus_wstrb <= mem_store ? st_strb : 4'd0;
                  bus_wdata <= st_data;
                  f3_q      <= mem_funct3;
                  off_q     <= mem_addr[1:0];
                  ld_q      <= mem_load;
                  cnt       <= 8'd0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (bus_ack) begin
                  if (ld_q)
                     rdata <= ld_ext;
                  rdata_valid <= ld_q;
                  bus_req     <= 1'b0;
                  cnt         <= 8'd0;
                  state       <= DONE;
               end else if (cnt == 8'(TIMEOUT - 1)) begin
                  bus_err <= 1'b1;
                  bus_req <= 1'b0;
                  cnt     <= 8'd0;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               rdata_valid <= 1'b0;
               bus_err     <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a scripted bus responder
// and a scoreboard of expected load/error results.
module tb_mem_stage_lsu;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_load, mem_store;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr, mem_wdata;
   logic        stall, rdata_valid, misalign, bus_err;
   logic        bus_req, bus_we, bus_ack;
   logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;

   typedef struct {
      logic        rv;
      logic        err;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];
   int tests = 0;
   int fails = 0;

   mem_stage_lsu #(.WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_load(mem_load),
      .mem_store(mem_store), .mem_funct3(mem_funct3),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
      .misalign(misalign), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      mem_valid = 1'b0;
      mem_load  = 1'b0;
      mem_store = 1'b0;
      bus_ack   = 1'b0;
   endtask

   // One access; waits = busy cycles before ack (>=TO: never ack)
   task automatic op(input string tag, input logic ld,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int waits,
                     input logic [31:0] rw, input logic [3:0] xstrb,
                     input logic [31:0] xwd, input logic [31:0] xrd);
      exp_t e, g;
      int n, busy, xn;
      bit done;
      e.err = (waits >= TO);
      e.rv  = ld & !e.err;
      e.rd  = xrd;
      sb.push_back(e);
      xn = e.err ? TO + 1 : waits + 2;
      @(negedge clk);
      mem_valid = 1'b1; mem_load = ld; mem_store = !ld;
      mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
      bus_ack = 1'b0;
      #1;
      chk({tag, ":stall_issue"}, 32'(stall), 32'd1);
      chk({tag, ":misalign"}, 32'(misalign), 32'd0);
      n = 1; busy = 0; done = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         bus_ack = 1'b0;
         if (busy == 0) begin
            chk({tag, ":req"}, 32'(bus_req), 32'd1);
            chk({tag, ":we"}, 32'(bus_we), 32'(!ld));
            chk({tag, ":addr"}, bus_addr, {a[31:2], 2'b00});
            chk({tag, ":wstrb"}, 32'(bus_wstrb), 32'(xstrb));
            if (!ld)
               chk({tag, ":wdata"}, bus_wdata, xwd);
         end
         if (stall) begin
            n++;
            if (busy == waits) begin
               bus_ack = 1'b1;
               bus_rdata = rw;
            end
            busy++;
         end else begin
            done = 1;
         end
      end
      chk({tag, ":finished"}, 32'(done), 32'd1);
      chk({tag, ":stall_cycles"}, 32'(n), 32'(xn));
      chk({tag, ":req_dropped"}, 32'(bus_req), 32'd0);
      if (sb.size() == 0) begin
         chk({tag, ":sb_empty"}, 32'd1, 32'd0);
      end else begin
         g = sb.pop_front();
         chk({tag, ":rvalid"}, 32'(rdata_valid), 32'(g.rv));
         chk({tag, ":bus_err"}, 32'(bus_err), 32'(g.err));
         chk({tag, ":rdata"}, rdata, g.rd);
      end
   endtask

   task automatic mis(input string tag, input logic ld,
                      input logic [2:0] f3, input logic [31:0] a);
      @(negedge clk);
      mem_valid = 1'b1; mem_load = ld; mem_store = !ld;
      mem_funct3 = f3; mem_addr = a; mem_wdata = 32'h5555_5555;
      #1;
      chk({tag, ":misalign"}, 32'(misalign), 32'd1);
      chk({tag, ":stall"}, 32'(stall), 32'd0);
      @(negedge clk);
      chk({tag, ":no_req"}, 32'(bus_req), 32'd0);
      chk({tag, ":no_rvalid"}, 32'(rdata_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      mem_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
      mem_funct3 = 3'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
      bus_ack = 1'b0; bus_rdata = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst:stall", 32'(stall), 32'd0);
      chk("rst:req", 32'(bus_req), 32'd0);
      chk("rst:rdata", rdata, 32'd0);
      chk("rst:rvalid", 32'(rdata_valid), 32'd0);
      chk("rst:err", 32'(bus_err), 32'd0);
      chk("rst:wstrb", 32'(bus_wstrb), 32'd0);
      chk("rst:addr", bus_addr, 32'd0);
      rst = 1'b0;

      op("tmo", 1, 3'b010, 32'h40, 0, 99, 0, 4'h0, 0, 32'h0);
      op("lw", 1, 3'b010, 32'h10, 0, 0, 32'hDEADBEEF, 4'h0, 0,
         32'hDEADBEEF);
      op("lb", 1, 3'b000, 32'h13, 0, 0, 32'h80FF0000, 4'h0, 0,
         32'hFFFFFF80);
      op("lbu", 1, 3'b100, 32'h13, 0, 0, 32'h80FF0000, 4'h0, 0,
         32'h00000080);
      op("lh", 1, 3'b001, 32'h12, 0, 1, 32'h80FF0000, 4'h0, 0,
         32'hFFFF80FF);
      op("lhu", 1, 3'b101, 32'h12, 0, 2, 32'h80FF0000, 4'h0, 0,
         32'h000080FF);
      op("sb", 0, 3'b000, 32'h21, 32'hAB, 0, 0, 4'b0010,
         32'hABABABAB, 32'h000080FF);
      op("sh", 0, 3'b001, 32'h22, 32'h0000BEEF, 1, 0, 4'b1100,
         32'hBEEFBEEF, 32'h000080FF);
      op("sw", 0, 3'b010, 32'h24, 32'h11223344, 0, 0, 4'hF,
         32'h11223344, 32'h000080FF);
      op("lw_edge", 1, 3'b010, 32'h30, 0, TO - 1, 32'h12345678,
         4'h0, 0, 32'h12345678);

      mis("lw_mis", 1, 3'b010, 32'h06);
      mis("sh_mis", 0, 3'b001, 32'h03);
      idle();

      @(negedge clk);
      mem_valid = 1'b1; mem_load = 1'b1; mem_store = 1'b0;
      mem_funct3 = 3'b010; mem_addr = 32'h60;
      @(negedge clk);
      chk("rstbusy:req_before", 32'(bus_req), 32'd1);
      rst = 1'b1;
      mem_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rstbusy:req", 32'(bus_req), 32'd0);
      chk("rstbusy:stall", 32'(stall), 32'd0);
      @(negedge clk);
      bus_ack = 1'b1;
      bus_rdata = 32'hBADBAD00;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("late_ack:req", 32'(bus_req), 32'd0);
      chk("late_ack:rvalid", 32'(rdata_valid), 32'd0);
      chk("late_ack:rdata", rdata, 32'd0);

      op("lw_after", 1, 3'b010, 32'h50, 0, 0, 32'hCAFEF00D, 4'h0, 0,
         32'hCAFEF00D);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
